// File: rtl/dpram_param_be_if.sv
// dpram_param_be_if
//   Bus bundle for the parametrised simple dual-port RAM.
//   master : drives the write port (wen/waddr/wbe/d_in), the read port
//            (ren/raddr) and the clear request (clr); observes d_out,
//            d_valid and busy.
//   slave  : the RAM side, with the opposite directions.
//   clk/rst are not part of the bundle; they stay plain module ports.
interface dpram_param_be_if #(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);
  localparam int NB = DATA_W / BYTE_W;

  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [NB-1:0]     wbe;
  logic [DATA_W-1:0] d_in;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              clr;
  logic [DATA_W-1:0] d_out;
  logic              d_valid;
  logic              busy;

  modport master (
    output wen, waddr, wbe, d_in, ren, raddr, clr,
    input  d_out, d_valid, busy
  );

  modport slave (
    input  wen, waddr, wbe, d_in, ren, raddr, clr,
    output d_out, d_valid, busy
  );
endinterface

// File: rtl/dpram_param_be.sv
// dpram_param_be
//   Parametrised simple dual-port RAM with byte-lane write enables,
//   1- or 2-stage read latency, selectable read-during-write policy and a
//   clear engine that zeroes the array after reset or on a clr request.
// Ports
//   clk : single clock for both ports
//   rst : asynchronous active-high reset (pipeline + FSM; array not reset)
//   bus : dpram_param_be_if.slave
//         wen/waddr/wbe/d_in : write port, wbe lane i covers d_in[i*BYTE_W +: BYTE_W]
//         ren/raddr          : read port
//         clr                : request to zero the whole array
//         d_out/d_valid      : registered read data and one-cycle valid pulse
//         busy               : clear engine active, all accesses ignored
module dpram_param_be #(
  parameter int DATA_W      = 64,
  parameter int BYTE_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  dpram_param_be_if.slave  bus
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  ccnt_reg;
  logic              busy_reg;
  logic [DATA_W-1:0] d_out_reg;
  logic              d_valid_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_valid_reg;

  // Accesses are accepted only in RUN and not in the cycle clr is sampled.
  logic acc_ok;
  logic rd_fire;
  logic wr_fire;
  logic collision;
  logic r_in_range;
  logic w_in_range;
  logic clear_wr;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rd_word;

  assign acc_ok     = (state_reg == RUN) && !bus.clr;
  assign r_in_range = {1'b0, bus.raddr} < DEPTH_C;
  assign w_in_range = {1'b0, bus.waddr} < DEPTH_C;
  assign rd_fire    = acc_ok && bus.ren;
  assign wr_fire    = acc_ok && bus.wen && w_in_range;
  assign collision  = wr_fire && rd_fire && (bus.raddr == bus.waddr);
  assign clear_wr   = (state_reg == CLEAR);
  assign widx       = bus.waddr[IDX_W-1:0];
  assign ridx       = bus.raddr[IDX_W-1:0];

  // One storage array per byte lane, so each lane's write enable maps
  // directly onto its own RAM column.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH];
    logic              bypass;

    always_ff @(posedge clk) begin
      if (clear_wr) begin
        lane_mem[ccnt_reg] <= '0;
      end else if (wr_fire && bus.wbe[gi]) begin
        lane_mem[widx] <= bus.d_in[gi*BYTE_W +: BYTE_W];
      end
    end

    // Write-first collisions forward the incoming lane; unwritten lanes
    // and read-first collisions see the pre-write contents.
    assign bypass = (WRITE_FIRST != 0) && collision && bus.wbe[gi];
    assign rd_word[gi*BYTE_W +: BYTE_W] =
      !r_in_range ? '0 :
      bypass      ? bus.d_in[gi*BYTE_W +: BYTE_W] :
                    lane_mem[ridx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CLEAR;
      ccnt_reg     <= '0;
      busy_reg     <= 1'b1;
      d_out_reg    <= '0;
      d_valid_reg  <= 1'b0;
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          // clr is deliberately ignored here: a running clear never restarts.
          if (ccnt_reg == LAST) begin
            state_reg <= RUN;
            ccnt_reg  <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ccnt_reg <= ccnt_reg + 1'b1;
          end
        end
        default: begin
          if (bus.clr) begin
            state_reg <= CLEAR;
            ccnt_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
      endcase

      if (RD_LAT == 1) begin
        d_valid_reg <= rd_fire;
        if (rd_fire) begin
          d_out_reg <= rd_word;
        end
      end else begin
        // A read in stage 1 is dropped if the next edge is not an
        // accepting one (clr sampled or clear engine running).
        s1_valid_reg <= rd_fire;
        if (rd_fire) begin
          s1_data_reg <= rd_word;
        end
        d_valid_reg <= s1_valid_reg && acc_ok;
        if (s1_valid_reg && acc_ok) begin
          d_out_reg <= s1_data_reg;
        end
      end
    end
  end

  assign bus.d_out   = d_out_reg;
  assign bus.d_valid = d_valid_reg;
  assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_dpram_param_be.sv
// tb_dpram_param_be
//   Two instances share one stimulus stream:
//     u_a : RD_LAT=1, WRITE_FIRST=0
//     u_b : RD_LAT=2, WRITE_FIRST=1
//   A cycle model of the array and FSM pushes expected read words with
//   their due edge into one queue per instance; every cycle the outputs
//   are compared against the queue heads, busy against the model state.
module tb_dpram_param_be;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int DP = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [7:0]    wbe = '0;
  logic [DW-1:0] d_in = '0;
  logic          ren = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          clr = 1'b0;

  always #5 clk = ~clk;

  dpram_param_be_if #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW)) ifa ();
  dpram_param_be_if #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW)) ifb ();

  assign ifa.wen = wen;   assign ifb.wen = wen;
  assign ifa.waddr = waddr; assign ifb.waddr = waddr;
  assign ifa.wbe = wbe;   assign ifb.wbe = wbe;
  assign ifa.d_in = d_in; assign ifb.d_in = d_in;
  assign ifa.ren = ren;   assign ifb.ren = ren;
  assign ifa.raddr = raddr; assign ifb.raddr = raddr;
  assign ifa.clr = clr;   assign ifb.clr = clr;

  dpram_param_be #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(DP),
                   .RD_LAT(1), .WRITE_FIRST(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  dpram_param_be #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(DP),
                   .RD_LAT(2), .WRITE_FIRST(1))
    u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // Model state
  logic [DW-1:0] mem [DP];
  bit            m_clear;
  int            m_ccnt;
  int            edge_n;
  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    bit   va;
    bit   vb;
    exp_t e;
    va = (qa.size() > 0) && (qa[0].due == edge_n);
    vb = (qb.size() > 0) && (qb[0].due == edge_n);
    chk("a_busy", {63'd0, ifa.busy}, {63'd0, m_clear});
    chk("b_busy", {63'd0, ifb.busy}, {63'd0, m_clear});
    chk("a_valid", {63'd0, ifa.d_valid}, {63'd0, va});
    chk("b_valid", {63'd0, ifb.d_valid}, {63'd0, vb});
    if (va) begin
      e = qa.pop_front();
      last_a = e.data;
    end
    if (vb) begin
      e = qb.pop_front();
      last_b = e.data;
    end
    chk("a_dout", ifa.d_out, last_a);
    chk("b_dout", ifb.d_out, last_b);
    $display("[TB] edge %0d wen=%0b wa=%0d ren=%0b ra=%0d clr=%0b | A v=%0b d=%h | B v=%0b d=%h busy=%0b",
             edge_n, wen, waddr, ren, raddr, clr, ifa.d_valid, ifa.d_out,
             ifb.d_valid, ifb.d_out, ifa.busy);
  endtask

  // Called at a falling edge with the inputs for the coming edge applied.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] oldw;
    logic [DW-1:0] neww;
    exp_t          e;
    acc = !m_clear && !clr;
    edge_n++;
    if (!acc) begin
      while (qb.size() > 0 && qb[$].due == edge_n) void'(qb.pop_back());
    end
    if (acc && ren) begin
      oldw = (raddr < DP) ? mem[raddr[3:0]] : '0;
      neww = oldw;
      if (wen && waddr == raddr && raddr < DP) begin
        for (int i = 0; i < 8; i++)
          if (wbe[i]) neww[i*8 +: 8] = d_in[i*8 +: 8];
      end
      e.data = oldw; e.due = edge_n;     qa.push_back(e);
      e.data = neww; e.due = edge_n + 1; qb.push_back(e);
    end
    if (m_clear) begin
      mem[m_ccnt] = '0;
      if (m_ccnt == DP - 1) m_clear = 1'b0;
      m_ccnt++;
    end else if (clr) begin
      m_clear = 1'b1;
      m_ccnt  = 0;
    end else if (wen && waddr < DP) begin
      for (int i = 0; i < 8; i++)
        if (wbe[i]) mem[waddr[3:0]][i*8 +: 8] = d_in[i*8 +: 8];
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive(input bit w, input int wa, input logic [7:0] be, input logic [DW-1:0] d,
                       input bit r, input int ra, input bit c);
    wen = w; waddr = AW'(wa); wbe = be; d_in = d;
    ren = r; raddr = AW'(ra); clr = c;
    tick();
  endtask

  task automatic idle();                                   drive(0, 0, 8'h00, '0, 0, 0, 0); endtask
  task automatic wr(input int a, input logic [7:0] be, input logic [DW-1:0] d); drive(1, a, be, d, 0, 0, 0); endtask
  task automatic rd(input int a);                          drive(0, 0, 8'h00, '0, 1, a, 0); endtask

  // Called at a falling edge; holds rst for one rising edge.
  task automatic do_reset();
    wen = 0; ren = 0; clr = 0; wbe = '0; d_in = '0; waddr = '0; raddr = '0;
    rst = 1'b1;
    #1;
    m_clear = 1'b1; m_ccnt = 0;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    chk("rst_a_dout", ifa.d_out, '0);
    chk("rst_b_dout", ifb.d_out, '0);
    chk("rst_a_valid", {63'd0, ifa.d_valid}, '0);
    chk("rst_b_valid", {63'd0, ifb.d_valid}, '0);
    chk("rst_busy", {63'd0, ifa.busy & ifb.busy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DP; i++) mem[i] = 'x;
    edge_n = 0;
    @(negedge clk);
    do_reset();

    // 1: clear after reset, then every word reads back zero
    for (int i = 0; i < DP; i++) idle();
    for (int i = 0; i < DP; i++) rd(i);
    idle(); idle();

    // Out-of-range read must return 0, not the aliased word
    wr(4, 8'hFF, 64'hCAFE_F00D_1234_5678);
    rd(20);
    idle(); idle();

    // 2: byte-lane merge
    wr(5, 8'hFF, 64'h0123_4567_89AB_CDEF);
    wr(5, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(5);
    chk("t2_merge", ifa.d_out, 64'h0123_4567_FFFF_FFFF);
    idle();
    wr(21, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);   // out of range: dropped
    wr(5, 8'h00, 64'h0);                      // no lanes: no change
    rd(5);
    idle(); idle();

    // 3: back-to-back reads
    wr(1, 8'hFF, 64'h11); wr(2, 8'hFF, 64'h22);
    wr(3, 8'hFF, 64'h33); wr(4, 8'hFF, 64'h44);
    rd(1); rd(2); rd(3); rd(4);
    idle(); idle(); idle();

    // 4: collisions, full word and partial lanes
    wr(7, 8'hFF, 64'hAA);
    drive(1, 7, 8'hFF, 64'h55, 1, 7, 0);
    idle();
    chk("t4_wf1", ifb.d_out, 64'h55);
    rd(7);
    wr(8, 8'hFF, 64'h1111_1111_1111_1111);
    drive(1, 8, 8'hF0, 64'h2222_2222_2222_2222, 1, 8, 0);
    idle(); idle();

    // 5: clr with a 2-stage read in flight
    rd(3);
    drive(0, 0, 8'h00, '0, 1, 3, 1);
    for (int i = 0; i < DP; i++) begin
      if (i == 5) drive(0, 0, 8'h00, '0, 0, 0, 1);   // ignored mid-clear
      else idle();
    end
    rd(3);
    idle(); idle();

    // 6: reset mid-clear, then writes during busy are ignored
    wr(2, 8'hFF, 64'hDEAD_0000_BEEF_0002);
    rd(2);
    idle(); idle();
    drive(0, 0, 8'h00, '0, 0, 0, 1);
    for (int i = 0; i < 9; i++) idle();
    do_reset();
    for (int i = 0; i < DP; i++)
      drive(1, i, 8'hFF, 64'h0BAD_0000_0000_0000 | 64'(i), 1, i, 0);
    for (int i = 0; i < DP; i++) rd(i);
    idle(); idle(); idle();

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
